// File: rtl/chord_song_reader.sv
// chord_song_reader: steps through one song of the song ROM and produces the
// chord player's control stream. Each ROM entry becomes either a note load
// or a time advance. The reader waits on the player's note_done and
// activate_done handshakes and pulses song_done once at the end of the song.
module chord_song_reader #(
   parameter int ENTRY_BITS = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_play,
   input  logic [1:0]            i_song,
   input  logic                  i_note_done,
   input  logic                  i_activate_done,
   input  logic                  i_beat,
   output logic [ENTRY_BITS+1:0] o_rom_addr,
   input  logic [12:0]           i_rom_data,
   output logic [5:0]            o_note_to_load,
   output logic [5:0]            o_duration,
   output logic                  o_load_new_note,
   output logic                  o_activate,
   output logic                  o_song_done
);

   localparam logic [2:0] FETCH      = 3'd0;
   localparam logic [2:0] WAIT_ROM   = 3'd1;
   localparam logic [2:0] DECODE     = 3'd2;
   localparam logic [2:0] WAIT_SLOT  = 3'd3;
   localparam logic [2:0] WAIT_TIMER = 3'd4;
   localparam logic [2:0] ARM        = 3'd5;
   localparam logic [2:0] WAIT_ADV   = 3'd6;
   localparam logic [2:0] DONE       = 3'd7;

   logic [2:0]            r_state;
   logic [ENTRY_BITS-1:0] r_entry_idx;
   logic [1:0]            r_song_q;
   logic [12:0]           r_entry_q;
   logic [ENTRY_BITS+1:0] r_rom_addr;
   logic                  r_done_sent;

   logic                  w_song_change;
   logic                  w_active;
   logic                  w_load;
   logic                  w_done_pulse;
   logic [2:0]            w_skip_state;
   logic [ENTRY_BITS-1:0] w_skip_idx;
   logic                  w_unused;

   // The beat tick is reserved for future use; it does not pace the reader.
   assign w_unused = i_beat;

   // A song change (while running) overrides everything, including a strobe
   // that would otherwise fire this cycle.
   assign w_song_change = i_play && (i_song != r_song_q);
   assign w_active      = i_play && !w_song_change;

   assign w_load = w_active &&
                   (((r_state == WAIT_SLOT)  && i_note_done) ||
                    ((r_state == WAIT_TIMER) && i_activate_done));

   // Only the first running cycle in DONE pulses; r_done_sent remembers it.
   assign w_done_pulse = w_active && (r_state == DONE) && !r_done_sent;

   assign o_rom_addr      = r_rom_addr;
   assign o_load_new_note = w_load;
   assign o_activate      = w_load && (r_state == WAIT_TIMER);
   assign o_note_to_load  = w_load ? r_entry_q[11:6] : 6'd0;
   assign o_duration      = w_load ? r_entry_q[5:0]  : 6'd0;
   assign o_song_done     = w_done_pulse;

   // Move to the next entry; the last entry of a song ends it without wrapping.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_skip_state = FETCH;
      w_skip_idx   = r_entry_idx + ENTRY_BITS'(1);
      if (&r_entry_idx) begin
         w_skip_state = DONE;
         w_skip_idx   = r_entry_idx;
      end
   end

   // Sequencer state, entry pointer and ROM address register.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_reset) begin
         r_state     <= FETCH;
         r_entry_idx <= '0;
         r_song_q    <= i_song;
         r_entry_q   <= '0;
         r_rom_addr  <= {i_song, {ENTRY_BITS{1'b0}}};
         r_done_sent <= 1'b0;
      end else if (w_song_change) begin
         r_state     <= FETCH;
         r_entry_idx <= '0;
         r_song_q    <= i_song;
         r_rom_addr  <= {i_song, {ENTRY_BITS{1'b0}}};
         r_done_sent <= 1'b0;
      end else if (i_play) begin
         case (r_state)
            FETCH: begin
               r_rom_addr <= {r_song_q, r_entry_idx};
               r_state    <= WAIT_ROM;
            end
            WAIT_ROM: r_state <= DECODE;
            DECODE: begin
               r_entry_q <= i_rom_data;
               if (i_rom_data[11:0] == 12'd0) begin
                  r_state <= DONE;
               end else if (i_rom_data[5:0] == 6'd0) begin
                  r_state     <= w_skip_state;
                  r_entry_idx <= w_skip_idx;
               end else if (i_rom_data[12]) begin
                  r_state <= WAIT_TIMER;
               end else begin
                  r_state <= WAIT_SLOT;
               end
            end
            WAIT_SLOT: begin
               if (i_note_done) begin
                  r_state     <= w_skip_state;
                  r_entry_idx <= w_skip_idx;
               end
            end
            WAIT_TIMER: begin
               if (i_activate_done) r_state <= ARM;
            end
            // The timer is still loading here, so activate_done is stale.
            ARM: r_state <= WAIT_ADV;
            WAIT_ADV: begin
               if (i_activate_done) begin
                  r_state     <= w_skip_state;
                  r_entry_idx <= w_skip_idx;
               end
            end
            DONE: begin
               if (!r_done_sent) r_done_sent <= 1'b1;
            end
            default: r_state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_chord_song_reader.sv
// Testbench for chord_song_reader: a ROM model plus directed song sequences.
// Expected load/done events are queued by the stimulus process and checked
// by an independent negedge monitor. Timing is checked in the stimulus.
module tb_chord_song_reader;

   typedef struct packed {
      logic       is_done;
      logic       load;
      logic       act;
      logic [5:0] note;
      logic [5:0] dur;
   } evt_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic [1:0]  song;
   logic        note_done;
   logic        activate_done;
   logic        beat;
   logic [6:0]  rom_addr;
   logic [12:0] rom_data;
   logic [5:0]  note_to_load;
   logic [5:0]  duration;
   logic        load_new_note;
   logic        activate;
   logic        song_done;

   logic [12:0] rom [0:127];
   evt_t        exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   chord_song_reader #(.ENTRY_BITS(5)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_play          (play),
      .i_song          (song),
      .i_note_done     (note_done),
      .i_activate_done (activate_done),
      .i_beat          (beat),
      .o_rom_addr      (rom_addr),
      .i_rom_data      (rom_data),
      .o_note_to_load  (note_to_load),
      .o_duration      (duration),
      .o_load_new_note (load_new_note),
      .o_activate      (activate),
      .o_song_done     (song_done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data valid one cycle after the address.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] s);
      reset = 1'b1;
      song  = s;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Ticks until a strobe or song_done is visible; n = ticks taken.
   task automatic wait_evt(input int budget, output int n);
      n = 0;
      while (!(load_new_note || song_done) && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic push_load(input logic act, input logic [5:0] note, input logic [5:0] dur);
      evt_t e;
      e = '{is_done: 1'b0, load: 1'b1, act: act, note: note, dur: dur};
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      evt_t e;
      e = '{is_done: 1'b1, load: 1'b0, act: 1'b0, note: 6'd0, dur: 6'd0};
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every event must match the head of the queue.
   always @(negedge clk) begin
      evt_t got;
      evt_t e;
      got = '{is_done: song_done, load: load_new_note, act: activate,
              note: note_to_load, dur: duration};
      if (!reset) begin
         if (load_new_note || song_done) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_event", 32'(got), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("event", 32'(got), 32'(e));
            end
         end else begin
            check_eq("idle_outputs", 32'(got), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      for (int i = 0; i < 128; i++) rom[i] = 13'd0;
      // song 0: 32 valid notes, no end marker
      for (int i = 0; i < 32; i++) rom[i] = {1'b0, 6'(i + 1), 6'(i + 2)};
      // song 1: note, advance, note, zero-duration skip, end marker
      rom[32] = {1'b0, 6'd20, 6'd12};
      rom[33] = {1'b1, 6'd0,  6'd5};
      rom[34] = {1'b0, 6'd7,  6'd3};
      rom[35] = {1'b0, 6'd9,  6'd0};
      rom[36] = 13'd0;
      // song 2: advance first
      rom[64] = {1'b1, 6'd0, 6'd10};
      rom[65] = {1'b0, 6'd5, 6'd5};

      reset = 1'b1; play = 1'b1; song = 2'd1;
      note_done = 1'b1; activate_done = 1'b1; beat = 1'b0;

      // Reset state and first-note latency
      do_reset(2'd1);
      check_eq("reset_rom_addr", 32'(rom_addr), 32'd32);
      check_eq("reset_load", 32'(load_new_note), 32'd0);
      push_load(1'b0, 6'd20, 6'd12);
      wait_evt(20, n);
      check_eq("first_load_latency", 32'(n), 32'd3);

      // Advance entry with timer busy for 5 cycles
      tick();
      push_load(1'b1, 6'd0, 6'd5);
      wait_evt(20, n);
      check_eq("advance_latency", 32'(n), 32'd3);
      check_eq("advance_activate", 32'(activate), 32'd1);
      tick();
      activate_done = 1'b0;
      note_done     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq("adv_hold_rom_addr", 32'(rom_addr), 32'd33);
         tick();
      end
      activate_done = 1'b1;

      // Slot busy for 10 cycles
      for (int i = 0; i < 4; i++) tick();
      check_eq("slot_rom_addr", 32'(rom_addr), 32'd34);
      for (int i = 0; i < 10; i++) begin
         check_eq("slot_busy_no_load", 32'(load_new_note), 32'd0);
         tick();
      end
      push_load(1'b0, 6'd7, 6'd3);
      note_done = 1'b1;
      #1;
      check_eq("slot_free_load", 32'(load_new_note), 32'd1);

      // Zero-duration skip, then end marker
      tick();
      push_done();
      wait_evt(20, n);
      check_eq("done_latency", 32'(n), 32'd6);
      check_eq("done_pulse", 32'(song_done), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("done_rom_addr_hold", 32'(rom_addr), 32'd36);
         tick();
      end

      // Pause on the strobe cycle
      do_reset(2'd1);
      tick(); tick(); tick();
      play = 1'b0;
      #1;
      check_eq("paused_no_load", 32'(load_new_note), 32'd0);
      push_load(1'b0, 6'd20, 6'd12);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("paused_rom_addr", 32'(rom_addr), 32'd32);
      end
      play = 1'b1;
      #1;
      check_eq("resume_load", 32'(load_new_note), 32'd1);
      tick();

      // Song change 2 -> 0 during WAIT_ADV, then a full 32-entry song
      do_reset(2'd2);
      push_load(1'b1, 6'd0, 6'd10);
      wait_evt(20, n);
      check_eq("song2_adv_latency", 32'(n), 32'd3);
      tick();
      activate_done = 1'b0;
      tick();
      song = 2'd0;
      tick();
      check_eq("song_change_rom_addr", 32'(rom_addr), 32'd0);
      activate_done = 1'b1;
      for (int i = 0; i < 32; i++) push_load(1'b0, 6'(i + 1), 6'(i + 2));
      push_done();
      for (int i = 0; i < 32; i++) begin
         wait_evt(20, n);
         check_eq("song0_spacing", 32'(n), 32'd3);
         tick();
      end
      wait_evt(20, n);
      check_eq("song0_done_after_31", 32'(n), 32'd0);
      check_eq("song0_done_pulse", 32'(song_done), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("no_wrap_rom_addr", 32'(rom_addr), 32'd31);
         tick();
      end
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
